// File: rtl/input_conditioning_multi.sv
// input_conditioning_multi
//   Multi-channel push-button conditioner. Every channel has its own 2-flop synchroniser,
//   stable-interval debouncer and a registered one-cycle event strobe.
//
// Ports
//   Clock    : system clock, all state updates on the rising edge
//   Reset    : synchronous, active-high reset
//   a        : raw asynchronous button inputs, one bit per channel
//   A_pulse  : registered one-cycle event strobe per channel
//   Pressed  : registered debounced level per channel, 1 = pressed regardless of ACTIVE_LOW
//
// Optional feature macro: INPUT_COND_REPEAT_EN
//   When defined, a held press produces auto-repeat strobes. The first repeat comes
//   REPEAT_DELAY cycles after the press strobe, and later ones follow every
//   REPEAT_PERIOD cycles. Only EDGE_MODE 0 and 2 repeat.
//   When undefined, no repeat logic is built and one press gives at most one strobe.

module input_conditioning_multi #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 250
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] a,
  output logic [NUM_CH-1:0] A_pulse,
  output logic [NUM_CH-1:0] Pressed
);

  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic        PressLvl = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic        RelLvl   = ~PressLvl;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] st_q, st_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] pressed_q, pressed_d;
  logic [CntW-1:0]   cnt_q [NUM_CH];
  logic [CntW-1:0]   cnt_d [NUM_CH];

`ifdef INPUT_COND_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  // Down-counter to the next repeat strobe; it is only meaningful while st is pressed.
  logic [RptW-1:0] rpt_q [NUM_CH];
  logic [RptW-1:0] rpt_d [NUM_CH];
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = '0;
      pulse_d[i] = 1'b0;

      // The counter restarts on any bounce back to the accepted level.
      if (sync2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          st_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      if (st_d[i] != st_q[i]) begin
        if (st_d[i] == PressLvl) begin
          pulse_d[i] = (EDGE_MODE != 1);
        end else begin
          pulse_d[i] = (EDGE_MODE != 0);
        end
      end

      pressed_d[i] = (st_d[i] == PressLvl);

`ifdef INPUT_COND_REPEAT_EN
      rpt_d[i] = '0;
      if ((st_d[i] == PressLvl) && (st_q[i] != PressLvl)) begin
        rpt_d[i] = RptW'(REPEAT_DELAY - 1);
      end else if ((st_q[i] == PressLvl) && (st_d[i] == PressLvl) && (EDGE_MODE != 1)) begin
        // A release being accepted on this edge takes the other branch, so it never repeats.
        if (rpt_q[i] == '0) begin
          pulse_d[i] = 1'b1;
          rpt_d[i]   = RptW'(REPEAT_PERIOD - 1);
        end else begin
          rpt_d[i] = rpt_q[i] - 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= {NUM_CH{RelLvl}};
      sync2_q   <= {NUM_CH{RelLvl}};
      st_q      <= {NUM_CH{RelLvl}};
      pulse_q   <= '0;
      pressed_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
`ifdef INPUT_COND_REPEAT_EN
        rpt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q   <= a;
      sync2_q   <= sync1_q;
      st_q      <= st_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef INPUT_COND_REPEAT_EN
        rpt_q[i] <= rpt_d[i];
`endif
      end
    end
  end

  assign A_pulse = pulse_q;
  assign Pressed = pressed_q;

endmodule

// File: tb/tb_input_conditioning_multi.sv
// Scoreboard bench for input_conditioning_multi with DEBOUNCE_CYCLES=4 and active-low inputs.
// dut0 runs EDGE_MODE 0 and dut2 runs EDGE_MODE 2. With INPUT_COND_REPEAT_EN defined,
// dut_r exercises auto-repeat with REPEAT_DELAY 10 and REPEAT_PERIOD 5.
// A level driven at the falling edge with cycle count m is sampled at edge m+1. That channel
// then accepts the level at edge m+2+D, and its strobe can be seen at the falling edge where
// the count is m+2+D.

module tb_input_conditioning_multi;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] a0 = 4'hF, a2 = 4'hF;
  logic [3:0] p0, p2, pr0, pr2;

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int n_checks = 0;
  int n_fail   = 0;

  input_conditioning_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_MODE(0),
    .REPEAT_DELAY(1000), .REPEAT_PERIOD(250)
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .a(a0), .A_pulse(p0), .Pressed(pr0)
  );

  input_conditioning_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_MODE(2),
    .REPEAT_DELAY(1000), .REPEAT_PERIOD(250)
  ) dut2 (
    .Clock(Clock), .Reset(Reset), .a(a2), .A_pulse(p2), .Pressed(pr2)
  );

`ifdef INPUT_COND_REPEAT_EN
  logic [3:0] ar = 4'hF;
  logic [3:0] pr, prr;
  exp_t qr[$];

  input_conditioning_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_MODE(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_r (
    .Clock(Clock), .Reset(Reset), .a(ar), .A_pulse(pr), .Pressed(prr)
  );

  always @(negedge Clock) begin
    if (pr !== 4'b0000) begin
      exp_t e;
      n_checks++;
      if (qr.size() == 0) begin
        n_fail++;
        $display("FAIL rpt_unexpected: pulse %b at cycle %0d, none expected", pr, cyc);
      end else begin
        e = qr.pop_front();
        if (e.cyc != cyc || e.val !== pr) begin
          n_fail++;
          $display("FAIL rpt_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   pr, cyc, e.val, e.cyc);
        end
      end
    end
  end
`endif

  // Monitors: every strobe the DUT shows must match the oldest expected entry.
  always @(negedge Clock) begin
    if (p0 !== 4'b0000) begin
      exp_t e;
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_unexpected: pulse %b at cycle %0d, none expected", p0, cyc);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || e.val !== p0) begin
          n_fail++;
          $display("FAIL dut0_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   p0, cyc, e.val, e.cyc);
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (p2 !== 4'b0000) begin
      exp_t e;
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL dut2_unexpected: pulse %b at cycle %0d, none expected", p2, cyc);
      end else begin
        e = q2.pop_front();
        if (e.cyc != cyc || e.val !== p2) begin
          n_fail++;
          $display("FAIL dut2_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   p2, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    step(3);
    check("reset_pressed0", pr0, 4'b0000);
    check("reset_pulse0", p0, 4'b0000);
    check("reset_pressed2", pr2, 4'b0000);
    check("reset_pulse2", p2, 4'b0000);
    Reset = 1'b0;
    step(2);

    // Single press on ch0; in mode 0 the release gives no strobe.
    a0[0] = 1'b0;
    q0.push_back('{cyc + 2 + D, 4'b0001});
    step(5);
    check("t1_pressed_before", pr0, 4'b0000);
    step(1);
    check("t1_pressed_after", pr0, 4'b0001);
    step(4);
    a0[0] = 1'b1;
    step(5);
    check("t1_release_before", pr0, 4'b0001);
    step(1);
    check("t1_release_after", pr0, 4'b0000);
    step(3);

    // ch1 bounce: a 3-cycle glitch, then a high cycle, then a long low run.
    a0[1] = 1'b0;
    step(3);
    a0[1] = 1'b1;
    step(1);
    a0[1] = 1'b0;
    q0.push_back('{cyc + 2 + D, 4'b0010});
    step(5);
    check("t2_no_glitch_accept", pr0, 4'b0000);
    step(1);
    check("t2_pressed", pr0, 4'b0010);
    step(4);
    a0[1] = 1'b1;
    step(8);
    check("t2_released", pr0, 4'b0000);

    // All channels pressed together.
    a0 = 4'b0000;
    q0.push_back('{cyc + 2 + D, 4'b1111});
    step(6);
    check("t5_all_pressed", pr0, 4'b1111);
    a0 = 4'b1111;
    step(8);
    check("t5_all_released", pr0, 4'b0000);

    // Reset while ch3 is held pressed; the channel then re-detects the press.
    a0[3] = 1'b0;
    q0.push_back('{cyc + 2 + D, 4'b1000});
    step(7);
    check("t4_pressed_pre_reset", pr0, 4'b1000);
    Reset = 1'b1;
    step(1);
    check("t4_reset_pressed", pr0, 4'b0000);
    check("t4_reset_pulse", p0, 4'b0000);
    Reset = 1'b0;
    q0.push_back('{cyc + 2 + D, 4'b1000});
    step(5);
    check("t4_repress_before", pr0, 4'b0000);
    step(1);
    check("t4_repress_after", pr0, 4'b1000);
    a0[3] = 1'b1;
    step(8);

    // EDGE_MODE 2: ch2 pressed for 20 cycles gives one strobe per accepted edge.
    a2[2] = 1'b0;
    q2.push_back('{cyc + 2 + D, 4'b0100});
    step(6);
    check("t3_pressed", pr2, 4'b0100);
    step(14);
    a2[2] = 1'b1;
    q2.push_back('{cyc + 2 + D, 4'b0100});
    step(5);
    check("t3_still_pressed", pr2, 4'b0100);
    step(1);
    check("t3_released", pr2, 4'b0000);
    step(3);

    // EDGE_MODE 2 with all channels pressed and released together.
    a2 = 4'b0000;
    q2.push_back('{cyc + 2 + D, 4'b1111});
    step(10);
    a2 = 4'b1111;
    q2.push_back('{cyc + 2 + D, 4'b1111});
    step(10);
    check("t5b_released", pr2, 4'b0000);

`ifdef INPUT_COND_REPEAT_EN
    // Auto-repeat. The release is accepted on the edge where the next repeat would land.
    begin
      int b;
      b = cyc;
      ar[0] = 1'b0;
      qr.push_back('{b + 6, 4'b0001});
      qr.push_back('{b + 16, 4'b0001});
      qr.push_back('{b + 21, 4'b0001});
      qr.push_back('{b + 26, 4'b0001});
      qr.push_back('{b + 31, 4'b0001});
      qr.push_back('{b + 36, 4'b0001});
      step(35);
      ar[0] = 1'b1;
      step(15);
      check("t6_released", prr, 4'b0000);
      n_checks++;
      if (qr.size() != 0) begin
        n_fail++;
        $display("FAIL rpt_missing: %0d expected pulses not seen, required 0", qr.size());
      end
    end
`endif

    step(5);
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL dut0_missing: %0d expected pulses not seen, required 0", q0.size());
    end
    n_checks++;
    if (q2.size() != 0) begin
      n_fail++;
      $display("FAIL dut2_missing: %0d expected pulses not seen, required 0", q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
